// File: rtl/cpu_io_host.sv
// Host-side endpoint of the CPU word I/O handshake: an input FIFO that feeds
// input_data/input_ready, and an output FIFO that captures CPU output strobes.
module cpu_io_host #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] host_in_data,
    input  logic             host_in_valid,
    output logic             host_in_ready,
    output logic [WIDTH-1:0] input_data,
    output logic             input_ready,
    input  logic             input_ack,
    input  logic [WIDTH-1:0] output_data,
    input  logic             output_ready,
    output logic [WIDTH-1:0] host_out_data,
    output logic             host_out_valid,
    input  logic             host_out_pop,
    output logic             overflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // ---------------- input FIFO ----------------
    logic [WIDTH-1:0] in_mem [DEPTH];
    logic [AW-1:0]    in_wr, in_rd;
    logic [CW-1:0]    in_cnt;
    logic             push_in, pop_in;

    // Ready depends only on registered count; rst gating holds it low in reset.
    assign host_in_ready = rst && (in_cnt != FULL);
    assign input_ready   = (in_cnt != '0);
    assign input_data    = in_mem[in_rd];
    assign push_in       = host_in_valid && host_in_ready;
    assign pop_in        = input_ack && input_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_wr  <= '0;
            in_rd  <= '0;
            in_cnt <= '0;
        end else begin
            if (push_in) in_wr <= in_wr + AW'(1);
            if (pop_in)  in_rd <= in_rd + AW'(1);
            if (push_in && !pop_in)      in_cnt <= in_cnt + CW'(1);
            else if (pop_in && !push_in) in_cnt <= in_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_in) in_mem[in_wr] <= host_in_data;
    end

    // ---------------- output capture + FIFO ----------------
    logic [WIDTH-1:0] out_mem [DEPTH];
    logic [AW-1:0]    out_wr, out_rd;
    logic [CW-1:0]    out_cnt;
    logic             prev_ord, capture, accept, pop_out, out_full;

    // prev_ord resets to 1 so a strobe held across reset release is ignored.
    assign capture        = output_ready && !prev_ord;
    assign out_full       = (out_cnt == FULL);
    assign host_out_valid = (out_cnt != '0);
    assign host_out_data  = out_mem[out_rd];
    assign pop_out        = host_out_pop && host_out_valid;
    assign accept         = capture && (!out_full || pop_out);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_wr   <= '0;
            out_rd   <= '0;
            out_cnt  <= '0;
            prev_ord <= 1'b1;
            overflow <= 1'b0;
        end else begin
            prev_ord <= output_ready;
            if (accept)  out_wr <= out_wr + AW'(1);
            if (pop_out) out_rd <= out_rd + AW'(1);
            if (accept && !pop_out)      out_cnt <= out_cnt + CW'(1);
            else if (pop_out && !accept) out_cnt <= out_cnt - CW'(1);
            if (capture && out_full && !pop_out) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) out_mem[out_wr] <= output_data;
    end

endmodule

// File: tb/tb_cpu_io_host.sv
// Directed bench for cpu_io_host: per-cycle vector tables for both FIFOs plus
// hand sequences for reset-related corners.
module tb_cpu_io_host;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] host_in_data, input_data, output_data, host_out_data;
    logic        host_in_valid, host_in_ready, input_ready, input_ack;
    logic        output_ready, host_out_valid, host_out_pop, overflow;

    int n_chk  = 0;
    int n_fail = 0;

    cpu_io_host #(.WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .host_in_data(host_in_data), .host_in_valid(host_in_valid),
        .host_in_ready(host_in_ready),
        .input_data(input_data), .input_ready(input_ready), .input_ack(input_ack),
        .output_data(output_data), .output_ready(output_ready),
        .host_out_data(host_out_data), .host_out_valid(host_out_valid),
        .host_out_pop(host_out_pop), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ack;
        logic        ord;
        logic [31:0] od;
        logic        pop;
        logic        e_hir;
        logic        e_ir;
        logic [31:0] e_id;
        logic        e_hov;
        logic [31:0] e_hod;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Input-side vector; output side idle and empty.
    task automatic ai(input logic iv, input logic [31:0] id, input logic ack,
                      input logic hir, input logic ir, input logic [31:0] idat);
        vec_t v;
        v = '{iv, id, ack, 1'b0, 32'h0, 1'b0, hir, ir, idat, 1'b0, 32'h0, 1'b0};
        vecs.push_back(v);
    endtask

    // Output-side vector; input side idle and empty.
    task automatic ao(input logic ord, input logic [31:0] od, input logic pop,
                      input logic hov, input logic [31:0] hod, input logic ovf);
        vec_t v;
        v = '{1'b0, 32'h0, 1'b0, ord, od, pop, 1'b1, 1'b0, 32'h0, hov, hod, ovf};
        vecs.push_back(v);
    endtask

    task automatic idle();
        host_in_valid = 0; host_in_data = '0; input_ack = 0;
        output_ready = 0; output_data = '0; host_out_pop = 0;
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) begin
            @(negedge clk);
            host_in_valid = vecs[i].iv;  host_in_data = vecs[i].id;
            input_ack     = vecs[i].ack; output_ready = vecs[i].ord;
            output_data   = vecs[i].od;  host_out_pop = vecs[i].pop;
            #1;
            chk($sformatf("v%0d host_in_ready", i), 32'(host_in_ready), 32'(vecs[i].e_hir));
            chk($sformatf("v%0d input_ready", i), 32'(input_ready), 32'(vecs[i].e_ir));
            if (vecs[i].e_ir) chk($sformatf("v%0d input_data", i), input_data, vecs[i].e_id);
            chk($sformatf("v%0d host_out_valid", i), 32'(host_out_valid), 32'(vecs[i].e_hov));
            if (vecs[i].e_hov) chk($sformatf("v%0d host_out_data", i), host_out_data, vecs[i].e_hod);
            chk($sformatf("v%0d overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
        end
        vecs.delete();
    endtask

    initial begin
        idle();
        rst = 0;
        // Expected values describe outputs before the edge that applies the inputs.
        // Single word, latency and ack; ack while empty ignored.
        ai(1, 32'd5, 0, 1, 0, 0);
        ai(0, 0,     1, 1, 1, 32'd5);
        ai(0, 0,     1, 1, 0, 0);
        // Fill to full; the 5th offer (9) is refused, even alongside an ack.
        ai(1, 32'd1, 0, 1, 0, 0);
        ai(1, 32'd2, 0, 1, 1, 32'd1);
        ai(1, 32'd3, 0, 1, 1, 32'd1);
        ai(1, 32'd4, 0, 1, 1, 32'd1);
        ai(1, 32'd9, 0, 0, 1, 32'd1);
        ai(1, 32'd9, 1, 0, 1, 32'd1);
        ai(0, 0,     1, 1, 1, 32'd2);
        ai(0, 0,     1, 1, 1, 32'd3);
        ai(0, 0,     1, 1, 1, 32'd4);
        ai(0, 0,     0, 1, 0, 0);
        // Simultaneous push and pop keeps count at 1.
        ai(1, 32'd7, 0, 1, 0, 0);
        ai(1, 32'd8, 1, 1, 1, 32'd7);
        ai(0, 0,     1, 1, 1, 32'd8);
        ai(0, 0,     0, 1, 0, 0);
        // Held strobe captures once; second strobe; ordered pops.
        ao(1, 32'h2A, 0, 0, 0, 0);
        ao(1, 32'hFF, 0, 1, 32'h2A, 0);
        ao(1, 32'hFF, 0, 1, 32'h2A, 0);
        ao(0, 0,      0, 1, 32'h2A, 0);
        ao(1, 32'h2B, 0, 1, 32'h2A, 0);
        ao(0, 0,      1, 1, 32'h2A, 0);
        ao(0, 0,      1, 1, 32'h2B, 0);
        ao(0, 0,      0, 0, 0, 0);
        // Overflow: 10..13 stored, 14 dropped; 20 accepted while full with pop.
        ao(1, 32'd10, 0, 0, 0, 0);
        ao(0, 0,      0, 1, 32'd10, 0);
        ao(1, 32'd11, 0, 1, 32'd10, 0);
        ao(0, 0,      0, 1, 32'd10, 0);
        ao(1, 32'd12, 0, 1, 32'd10, 0);
        ao(0, 0,      0, 1, 32'd10, 0);
        ao(1, 32'd13, 0, 1, 32'd10, 0);
        ao(0, 0,      0, 1, 32'd10, 0);
        ao(1, 32'd14, 0, 1, 32'd10, 0);
        ao(0, 0,      0, 1, 32'd10, 1);
        ao(1, 32'd20, 1, 1, 32'd10, 1);
        ao(0, 0,      1, 1, 32'd11, 1);
        ao(0, 0,      1, 1, 32'd12, 1);
        ao(0, 0,      1, 1, 32'd13, 1);
        ao(0, 0,      1, 1, 32'd20, 1);
        ao(0, 0,      0, 0, 0, 1);

        // Reset state
        #12;
        chk("rst host_in_ready", 32'(host_in_ready), 0);
        chk("rst input_ready", 32'(input_ready), 0);
        chk("rst host_out_valid", 32'(host_out_valid), 0);
        chk("rst overflow", 32'(overflow), 0);
        @(negedge clk); rst = 1;
        @(negedge clk);

        run_vecs();

        // Mid-stream reset: two words in each FIFO, overflow still set.
        @(negedge clk); idle(); host_in_valid = 1; host_in_data = 32'hA1;
        output_ready = 1; output_data = 32'hB1;
        @(negedge clk); host_in_data = 32'hA2; output_ready = 0;
        @(negedge clk); host_in_valid = 0; output_ready = 1; output_data = 32'hB2;
        @(negedge clk); output_ready = 1;
        #1;
        chk("pre-rst input_data", input_data, 32'hA1);
        chk("pre-rst host_out_data", host_out_data, 32'hB1);
        chk("pre-rst overflow", 32'(overflow), 1);
        #2 rst = 0;
        #1;
        chk("async input_ready", 32'(input_ready), 0);
        chk("async host_out_valid", 32'(host_out_valid), 0);
        chk("async overflow", 32'(overflow), 0);
        chk("async host_in_ready", 32'(host_in_ready), 0);
        // output_ready stays high across release: must not capture.
        @(negedge clk); rst = 1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("post-rst input_ready", 32'(input_ready), 0);
            chk("post-rst host_out_valid", 32'(host_out_valid), 0);
            chk("post-rst host_in_ready", 32'(host_in_ready), 1);
        end
        output_ready = 0;
        @(negedge clk); output_ready = 1; output_data = 32'h77;
        @(negedge clk); output_ready = 0; output_data = 32'h0; #1;
        chk("fresh capture valid", 32'(host_out_valid), 1);
        chk("fresh capture data", host_out_data, 32'h77);
        host_out_pop = 1;
        @(negedge clk); host_out_pop = 0; #1;
        chk("single capture", 32'(host_out_valid), 0);
        chk("overflow after reset", 32'(overflow), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
